// File: rtl/conv_rx_pkg.sv
// Shared types and helpers for the RX byte-to-word packer.
// Defines the packer FSM states, the FIFO headroom rule and the eop byte-count encoding.
package conv_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DROP
  } state_e;

  // One FIFO entry is always held back so a truncating eop word can still be written.
  localparam int FIFO_RESERVE = 1;

  // Valid-byte field of an eop word: a completely full word encodes as 0.
  function automatic int calc_mod(input int nbytes, input int data_bytes);
    return nbytes % data_bytes;
  endfunction

endpackage

// File: rtl/conv_rx_packer_if.sv
// Word stream leaving the RX packer: show-ahead valid/ready with frame markers.
interface conv_rx_packer_if #(
  parameter int DATA_BYTES = 8
);
  localparam int MOD_W = $clog2(DATA_BYTES);

  logic                    valid;
  logic                    ready;
  logic [DATA_BYTES*8-1:0] data;
  logic                    sop;
  logic                    eop;
  logic [MOD_W-1:0]        mod;
  logic                    err;

  modport master (output valid, data, sop, eop, mod, err, input ready);
  modport slave  (input valid, data, sop, eop, mod, err, output ready);

endinterface

// File: rtl/conv_sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible whenever empty_o is low.
// Reports the number of free entries so the writer can reserve headroom.
module conv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   free_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      used;
  logic             do_rd;

  assign used      = wr_ptr_q - rd_ptr_q;
  assign free_o    = DEPTH_V - used;
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define which entries are valid,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd)   rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/conv_rx_packer.sv
// Packs the enabled MAC byte stream into DATA_BYTES-wide words with sop/eop/mod/err,
// buffers them in a local FIFO and keeps saturating frame, runt and overflow counters.
module conv_rx_packer
  import conv_rx_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int DEPTH      = 16,
  parameter int MIN_BYTES  = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_mac_i,
  input  logic              rst_i,
  input  logic              clk_en_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_last_i,
  input  logic              in_err_i,
  conv_rx_packer_if.master  out_if,
  output logic [CNT_W-1:0]  frm_cnt_o,
  output logic [CNT_W-1:0]  runt_cnt_o,
  output logic [CNT_W-1:0]  ovf_cnt_o
);
  localparam int MOD_W  = $clog2(DATA_BYTES);
  localparam int WORD_W = DATA_BYTES * 8;
  localparam int FREE_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
    logic              err;
  } word_t;

  state_e            state_q, state_d;
  logic [MOD_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] asm_q, asm_d, word;
  logic              err_q, err_d;
  logic              sop_pend_q, sop_pend_d;
  word_t             stage1_q, stage1_d, stage2_q;
  logic              push1_q, push1_d, push2_q;
  logic              frm_inc, runt_inc, ovf_inc;
  logic [CNT_W-1:0]  frm_q, runt_q, ovf_q;
  logic [FREE_W-1:0] fifo_free;
  logic              fifo_empty, pop;
  word_t             rd_word;
  logic              first, err_now, room_ok;
  logic [MOD_W:0]    nbytes;

  // Words still in the two-stage write pipeline already own a FIFO slot.
  assign room_ok = (int'(fifo_free) - int'(push1_q) - int'(push2_q)) > FIFO_RESERVE;

  // NOTE: every variable written here gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    err_d      = err_q;
    sop_pend_d = sop_pend_q;
    stage1_d   = stage1_q;
    push1_d    = 1'b0;
    frm_inc    = 1'b0;
    runt_inc   = 1'b0;
    ovf_inc    = 1'b0;
    first      = (state_q == IDLE) || sop_pend_q;
    err_now    = err_q | in_err_i;
    nbytes     = {1'b0, idx_q} + (MOD_W+1)'(1);
    word       = asm_q;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (idx_q == MOD_W'(b)) word[b*8 +: 8] = in_data_i;
    end

    if (clk_en_i && in_valid_i) begin
      unique case (state_q)
        IDLE, PACK: begin
          if (state_q == IDLE && !room_ok) begin
            ovf_inc = 1'b1;
            state_d = in_last_i ? IDLE : DROP;
          end else if (in_last_i) begin
            // Runts can only be seen before the first push since MIN_BYTES <= DATA_BYTES.
            if (first && int'(nbytes) < MIN_BYTES) begin
              runt_inc = 1'b1;
            end else begin
              push1_d       = 1'b1;
              stage1_d.data = word;
              stage1_d.sop  = first;
              stage1_d.eop  = 1'b1;
              stage1_d.mod  = MOD_W'(calc_mod(int'(nbytes), DATA_BYTES));
              stage1_d.err  = err_now;
              frm_inc       = 1'b1;
            end
            state_d    = IDLE;
            idx_d      = '0;
            asm_d      = '0;
            err_d      = 1'b0;
            sop_pend_d = 1'b0;
          end else if (int'(idx_q) == DATA_BYTES - 1) begin
            push1_d       = 1'b1;
            stage1_d.data = word;
            stage1_d.sop  = first;
            stage1_d.mod  = '0;
            idx_d         = '0;
            asm_d         = '0;
            sop_pend_d    = 1'b0;
            if (room_ok) begin
              stage1_d.eop = 1'b0;
              stage1_d.err = 1'b0;
              err_d        = err_now;
              state_d      = PACK;
            end else begin
              // Close the frame in the reserved slot and discard the rest of it.
              stage1_d.eop = 1'b1;
              stage1_d.err = 1'b1;
              ovf_inc      = 1'b1;
              err_d        = 1'b0;
              state_d      = DROP;
            end
          end else begin
            asm_d      = word;
            idx_d      = idx_q + MOD_W'(1);
            err_d      = err_now;
            sop_pend_d = first;
            state_d    = PACK;
          end
        end
        DROP: begin
          if (in_last_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_mac_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      asm_q      <= '0;
      err_q      <= 1'b0;
      sop_pend_q <= 1'b0;
      stage1_q   <= '0;
      push1_q    <= 1'b0;
      stage2_q   <= '0;
      push2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      err_q      <= err_d;
      sop_pend_q <= sop_pend_d;
      stage1_q   <= stage1_d;
      push1_q    <= push1_d;
      stage2_q   <= stage1_q;
      push2_q    <= push1_q;
    end
  end

  always_ff @(posedge clk_mac_i or posedge rst_i) begin
    if (rst_i) begin
      frm_q  <= '0;
      runt_q <= '0;
      ovf_q  <= '0;
    end else begin
      if (frm_inc  && frm_q  != '1) frm_q  <= frm_q  + CNT_W'(1);
      if (runt_inc && runt_q != '1) runt_q <= runt_q + CNT_W'(1);
      if (ovf_inc  && ovf_q  != '1) ovf_q  <= ovf_q  + CNT_W'(1);
    end
  end

  conv_sync_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_mac_i),
    .rst_i     (rst_i),
    .wr_en_i   (push2_q),
    .wr_data_i (stage2_q),
    .rd_en_i   (pop),
    .rd_data_o (rd_word),
    .empty_o   (fifo_empty),
    .free_o    (fifo_free)
  );

  assign pop          = out_if.valid && out_if.ready;
  assign out_if.valid = !fifo_empty;
  assign out_if.data  = rd_word.data;
  assign out_if.sop   = rd_word.sop;
  assign out_if.eop   = rd_word.eop;
  assign out_if.mod   = rd_word.mod;
  assign out_if.err   = rd_word.err;

  assign frm_cnt_o  = frm_q;
  assign runt_cnt_o = runt_q;
  assign ovf_cnt_o  = ovf_q;

endmodule
